// File: rtl/demux_sel_sequencer_pkg.sv
// Shared types and constants for the demux select sequencer.
package demux_seq_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRE   = 2'd1,
    S_DRIVE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/demux_sel_sequencer_if.sv
// Control/config inputs and demux-facing outputs of the select sequencer.
interface demux_sel_sequencer_if #(
  parameter int DWELL_W = 8
);
  import demux_seq_pkg::*;

  logic               start_i;
  logic               stop_i;
  logic               continuous_i;
  logic [DWELL_W-1:0] pre_delay_i;
  logic [DWELL_W-1:0] dwell_i;
  logic [NUM_CH-1:0]  chan_mask_i;
  logic               data_o;
  logic [SEL_W-1:0]   sel_o;
  logic               busy_o;
  logic               step_o;
  logic               done_o;

  modport master (
    output start_i, stop_i, continuous_i, pre_delay_i, dwell_i, chan_mask_i,
    input  data_o, sel_o, busy_o, step_o, done_o
  );

  modport slave (
    input  start_i, stop_i, continuous_i, pre_delay_i, dwell_i, chan_mask_i,
    output data_o, sel_o, busy_o, step_o, done_o
  );

endinterface

// File: rtl/demux_sel_sequencer_next_ch.sv
// Finds the lowest enabled channel above cur; if none, flags wrap and
// returns the lowest enabled channel overall (with cur=top this gives the first).
module demux_seq_next_ch
  import demux_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  next_ch,
  output logic              wrap
);

  always_comb begin
    next_ch = '0;
    wrap    = 1'b1;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (mask[k] && (k > int'(cur))) begin
        next_ch = SEL_W'(k);
        wrap    = 1'b0;
      end
    end
    if (wrap) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (mask[k]) next_ch = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/demux_sel_sequencer.sv
// Sequences demux data/select through enabled channels after an optional
// pre-delay, single pass or continuous, with abort and done pulse.
module demux_sel_sequencer
  import demux_seq_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input logic                   clk_i,
  input logic                   rst_i,
  demux_sel_sequencer_if.slave  bus
);

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [NUM_CH-1:0]  mask_q;
  logic               cont_q;
  logic               step_q, step_d;
  logic               cfg_load;

  logic [NUM_CH-1:0]  find_mask;
  logic [SEL_W-1:0]   find_cur;
  logic [SEL_W-1:0]   find_ch;
  logic               find_wrap;

  // Dwell of 0 behaves as 1, so the down-counter load saturates at 0.
  function automatic logic [DWELL_W-1:0] load_val(input logic [DWELL_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  // One finder serves both "first channel" (IDLE/PRE) and "next channel" (DRIVE).
  always_comb begin
    if (state_q == S_DRIVE) begin
      find_mask = mask_q;
      find_cur  = ch_q;
    end else begin
      find_mask = (state_q == S_IDLE) ? bus.chan_mask_i : mask_q;
      find_cur  = SEL_W'(NUM_CH - 1);
    end
  end

  demux_seq_next_ch u_next_ch (
    .mask    (find_mask),
    .cur     (find_cur),
    .next_ch (find_ch),
    .wrap    (find_wrap)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    step_d   = 1'b0;
    cfg_load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          cfg_load = 1'b1;
          if (bus.chan_mask_i == '0) begin
            state_d = S_DONE;
          end else if (bus.pre_delay_i != '0) begin
            state_d = S_PRE;
            cnt_d   = bus.pre_delay_i - 1'b1;
          end else begin
            state_d = S_DRIVE;
            ch_d    = find_ch;
            cnt_d   = load_val(bus.dwell_i);
            step_d  = 1'b1;
          end
        end
      end
      S_PRE: begin
        if (bus.stop_i) begin
          state_d = S_DONE;
        end else if (cnt_q == '0) begin
          state_d = S_DRIVE;
          ch_d    = find_ch;
          cnt_d   = load_val(dwell_q);
          step_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DRIVE: begin
        if (bus.stop_i) begin
          state_d = S_DONE;
        end else if (cnt_q == '0) begin
          if (find_wrap && !cont_q) begin
            state_d = S_DONE;
          end else begin
            ch_d   = find_ch;
            cnt_d  = load_val(dwell_q);
            step_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      ch_q    <= '0;
      step_q  <= 1'b0;
      dwell_q <= '0;
      mask_q  <= '0;
      cont_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ch_q   <= ch_d;
      step_q <= step_d;
      if (cfg_load) begin
        dwell_q <= bus.dwell_i;
        mask_q  <= bus.chan_mask_i;
        cont_q  <= bus.continuous_i;
      end
    end
  end

  assign bus.data_o = (state_q == S_DRIVE);
  assign bus.sel_o  = (state_q == S_DRIVE) ? ch_q : '0;
  assign bus.busy_o = (state_q == S_PRE) || (state_q == S_DRIVE);
  assign bus.step_o = step_q;
  assign bus.done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Bench for demux_sel_sequencer: timing-formula model checked every cycle
// plus directed literal expectations.
module tb_demux_sel_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  demux_sel_sequencer_if #(.DWELL_W(8)) bus ();

  demux_sel_sequencer #(.DWELL_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int s_base = 0;
  int steps = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: phase 0 idle, 1 running (cycle m_t since start), 2 done cycle.
  int         m_phase, m_t, m_P, m_D;
  bit         m_cont;
  logic [3:0] m_mask;

  function automatic int n_en(input logic [3:0] m);
    int n = 0;
    for (int k = 0; k < 4; k++) if (m[k]) n++;
    return n;
  endfunction

  function automatic int nth_en(input logic [3:0] m, input int i);
    int n = 0;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        if (n == i) return k;
        n++;
      end
    end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_t     <= 0;
      m_P     <= 0;
      m_D     <= 1;
      m_cont  <= 1'b0;
      m_mask  <= 4'b0;
    end else begin
      case (m_phase)
        0: if (bus.start_i) begin
          m_P     <= int'(bus.pre_delay_i);
          m_D     <= (bus.dwell_i == 8'd0) ? 1 : int'(bus.dwell_i);
          m_cont  <= bus.continuous_i;
          m_mask  <= bus.chan_mask_i;
          m_t     <= 1;
          m_phase <= (bus.chan_mask_i == 4'b0) ? 2 : 1;
        end
        1: begin
          if (bus.stop_i) m_phase <= 2;
          else if (!m_cont && (m_t - m_P) >= n_en(m_mask) * m_D) m_phase <= 2;
          else m_t <= m_t + 1;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic       ed, eb, es, edn;
    logic [1:0] esel;
    int         k;
    ed = 1'b0; eb = 1'b0; es = 1'b0; edn = 1'b0; esel = 2'd0;
    if (m_phase == 2) begin
      edn = 1'b1;
    end else if (m_phase == 1) begin
      eb = 1'b1;
      if (m_t > m_P) begin
        k    = m_t - m_P - 1;
        ed   = 1'b1;
        esel = 2'(nth_en(m_mask, (k / m_D) % n_en(m_mask)));
        es   = ((k % m_D) == 0);
      end
    end
    total++;
    if ({bus.data_o, bus.sel_o, bus.busy_o, bus.step_o, bus.done_o} !== {ed, esel, eb, es, edn}) begin
      bad++;
      $display("FAIL model_cycle t=%0t got d=%b sel=%0d busy=%b step=%b done=%b want d=%b sel=%0d busy=%b step=%b done=%b",
               $time, bus.data_o, bus.sel_o, bus.busy_o, bus.step_o, bus.done_o, ed, esel, eb, es, edn);
    end
    if (bus.step_o === 1'b1) steps++;
  end

  task automatic chk_out(input string nm, input logic d, input logic [1:0] s,
                         input logic b, input logic st, input logic dn);
    total++;
    if ({bus.data_o, bus.sel_o, bus.busy_o, bus.step_o, bus.done_o} !== {d, s, b, st, dn}) begin
      bad++;
      $display("FAIL %s got d=%b sel=%0d busy=%b step=%b done=%b want d=%b sel=%0d busy=%b step=%b done=%b",
               nm, bus.data_o, bus.sel_o, bus.busy_o, bus.step_o, bus.done_o, d, s, b, st, dn);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic goto(input int c);
    int guard = 0;
    while ((cyc - s_base) < c && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic do_start(input logic [7:0] p, input logic [7:0] d, input logic [3:0] m,
                          input logic cont, input logic stp);
    @(negedge clk);
    bus.pre_delay_i  = p;
    bus.dwell_i      = d;
    bus.chan_mask_i  = m;
    bus.continuous_i = cont;
    bus.start_i      = 1'b1;
    bus.stop_i       = stp;
    s_base           = cyc;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.continuous_i = 1'b0;
    bus.pre_delay_i = 8'd0; bus.dwell_i = 8'd0; bus.chan_mask_i = 4'd0;
    #1;
    chk_out("reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Long pre-delay, four channels, single pass
    steps = 0;
    do_start(8'd50, 8'd20, 4'b1111, 1'b0, 1'b0);
    goto(50);  chk_out("t1_c50",  1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    goto(51);  chk_out("t1_c51",  1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
    goto(70);  chk_out("t1_c70",  1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    goto(71);  chk_out("t1_c71",  1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
    goto(91);  chk_out("t1_c91",  1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
    goto(111); chk_out("t1_c111", 1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
    goto(130); chk_out("t1_c130", 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    goto(131); chk_out("t1_c131", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    goto(132); chk_out("t1_c132", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk_int("t1_steps", steps, 4);

    // Zero pre-delay, zero dwell, sparse mask
    do_start(8'd0, 8'd0, 4'b1010, 1'b0, 1'b0);
    chk_out("t2_c1", 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
    goto(2); chk_out("t2_c2", 1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
    goto(3); chk_out("t2_c3", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    goto(4);

    // Empty mask
    do_start(8'd5, 8'd5, 4'b0000, 1'b0, 1'b0);
    chk_out("t3_c1", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    goto(2); chk_out("t3_c2", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Continuous with stop; start/config disturbance mid-run
    do_start(8'd0, 8'd3, 4'b0101, 1'b1, 1'b0);
    chk_out("t4_c1", 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
    goto(4); chk_out("t4_c4", 1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
    goto(5);
    bus.start_i = 1'b1; bus.chan_mask_i = 4'b1000; bus.dwell_i = 8'd9;
    bus.continuous_i = 1'b0; bus.pre_delay_i = 8'd7;
    @(negedge clk);
    bus.start_i = 1'b0;
    goto(7); chk_out("t4_c7", 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
    goto(10);
    bus.stop_i = 1'b1;
    @(negedge clk);
    bus.stop_i = 1'b0;
    chk_out("t4_c11", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    goto(12); chk_out("t4_c12", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-DRIVE, then fresh start with stop held in IDLE
    do_start(8'd2, 8'd4, 4'b1111, 1'b0, 1'b0);
    goto(6); chk_out("t5_c6", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1 chk_out("t5_rst", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_out("t5_post", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    do_start(8'd1, 8'd2, 4'b0110, 1'b0, 1'b1);
    chk_out("t6_c1", 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    goto(2); chk_out("t6_c2", 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
    goto(4); chk_out("t6_c4", 1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
    goto(6); chk_out("t6_c6", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    goto(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_sel_sequencer.md
# demux_sel_sequencer

Upstream stimulus/control stage for the 1-to-4 demultiplexer (`demux_4x1_top`). On a start command it drives `data_in_i`/`sel_i` of the demux. The sequence is an optional idle pre-delay, then `data_o=1` while stepping `sel_o` through the enabled output channels in ascending order, holding each channel for a programmable dwell. It runs once or loops continuously, with abort and completion signalling toward the system controller.

## Interface
- `DWELL_W`, default 8: width of the dwell and pre-delay counters.
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  start request, sampled only in IDLE.
- `stop_i`  in  1  abort request, sampled in PRE and DRIVE.
- `continuous_i`  in  1  latched at start: 1 = wrap and loop until stopped, 0 = single pass.
- `pre_delay_i`  in  DWELL_W  latched at start: number of idle cycles before the first channel.
- `dwell_i`  in  DWELL_W  latched at start: cycles per channel; 0 is treated as 1.
- `chan_mask_i`  in  4  latched at start: bit k enables channel k.
- `data_o`  out  1  connects to demux `data_in_i`.
- `sel_o`  out  2  connects to demux `sel_i`.
- `busy_o`  out  1  high in PRE and DRIVE.
- `step_o`  out  1  one-cycle pulse in the first hold cycle of each channel.
- `done_o`  out  1  one-cycle pulse at completion or abort.

## Operation
- Reset values: state IDLE, `data_o`=0, `sel_o`=0, `busy_o`=0, `step_o`=0, `done_o`=0, all counters 0, latched config 0.
- States: IDLE, PRE, DRIVE, DONE.
- **IDLE, `start_i`=1:** latch the config. If mask=0, go to DONE. Else if `pre_delay`>0, go to PRE. Else go to DRIVE on the lowest enabled channel.
- **PRE:** `data_o`=0 and `sel_o`=0 for exactly `pre_delay` cycles, then go to DRIVE.
- **DRIVE:**
  - `data_o`=1, `sel_o`=current channel, held for D = max(dwell,1) cycles.
  - After D cycles, advance to the next enabled channel above the current one.
  - If none remains: with continuous, wrap to the lowest enabled channel; otherwise go to DONE.
  - With a single enabled channel in continuous mode, the same channel re-holds and `step_o` pulses every D cycles.
- **DONE:** `data_o`=0, `sel_o`=0, `done_o`=1 for one cycle, then go to IDLE.
- **`stop_i`=1 in PRE or DRIVE:** go to DONE on the next edge, regardless of counters. `stop_i` is ignored in IDLE and DONE.
- Ignored inputs:
  - `start_i` outside IDLE.
  - `start_i` and `stop_i` together in IDLE: start is honoured and stop is ignored.
  - Config inputs changing after start have no effect until the next start.
- Counter arithmetic: unsigned DWELL_W-bit down-counters, loaded with (value−1). Counts never wrap.

## Timing
- Edge 0 is the edge that samples `start_i`. With P = pre_delay:
  - PRE occupies cycles 1..P.
  - Channel n of the enabled sequence occupies cycles P+1+n·D .. P+(n+1)·D.
  - DONE occupies the cycle after the last hold cycle.
- Mask=0: DONE in cycle 1, `busy_o` never asserts.
- `stop_i` sampled at edge k puts the block in DONE during cycle k+1, with `data_o`=0 in that cycle.
- All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.
- Asserting `rst_i` mid-sequence forces the reset values immediately. No `done_o` pulse is produced.

## Structure
- Package `demux_seq_pkg`: state enum (IDLE, PRE, DRIVE, DONE), `NUM_CH`=4, `SEL_W`=2.
- Sub-module `demux_seq_next_ch`: combinational next-enabled-channel finder. Inputs are mask and current channel; outputs are next channel and a wrap flag. It is also used to find the first channel.
- The top holds the FSM, the two counters and the config registers.

## Test plan
- P=50, D=20, mask=1111, single pass → `data_o` rises in cycle 51; `sel_o` is 0/1/2/3 over cycles 51–70/71–90/91–110/111–130; `done_o` pulses in cycle 131; four `step_o` pulses.
- P=0, D=0, mask=1010 → `sel_o`=1 in cycle 1, `sel_o`=3 in cycle 2, `done_o` in cycle 3.
- mask=0000 → `done_o` in cycle 1, `busy_o` stays 0, `data_o` stays 0.
- Continuous, D=3, mask=0101 → `sel_o` sequence 0,0,0,2,2,2,0,… repeating. `stop_i` at edge 10 → `done_o` in cycle 11, then IDLE.
- `rst_i` asserted mid-DRIVE → all outputs 0 asynchronously, no `done_o`. A fresh start then runs normally.
- `start_i` pulsed during DRIVE, and config changed during DRIVE → the running sequence is unchanged.
